mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
Game-sequencing controller for whack-a-mole. Samples the free-running 5-bit random value (range 1..30) and picks which hole shows a mole. Times how long the mole stays up and the gap between moles. Judges button hits against the active hole and keeps score, misses and round count until the game ends.

Parameters:
NUM_HOLES, 9, number of holes/buttons (2..16)
UP_TICKS, 20, ticks a mole stays up (1..255)
GAP_TICKS, 5, ticks with no mole between rounds (1..255)
ROUNDS, 30, moles per game (1..255)
MAX_MISSES, 5, misses that end the game early (1..255)
MIN_UP_TICKS, 6, floor for up time when SPEEDUP_EN is set (1..UP_TICKS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rand  in  5  random value from generator, valid every cycle
tick  in  1  one-cycle game-time enable
start  in  1  one-cycle start request
hit  in  NUM_HOLES  button pulses, one bit per hole, already debounced
mole  out  NUM_HOLES  one-hot active mole; all-zero when none
score  out  8  successful hits, saturating
misses  out  8  timed-out moles
round  out  8  moles spawned this game
hit_pulse  out  1  one cycle on a scored hit
miss_pulse  out  1  one cycle on a timeout
game_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; prev-hole-valid cleared; cur_up=UP_TICKS.
- States: IDLE, SPAWN, UP, GAP, OVER. All outputs registered.
- IDLE/OVER, start=1:
  - clear score, misses, round and prev-hole-valid; cur_up=UP_TICKS; game_over=0.
  - Next cycle: SPAWN.
  - start is ignored in SPAWN/UP/GAP.
- SPAWN (1 cycle):
  - idx = (rand-1) mod NUM_HOLES; rand=0 maps to idx 0.
  - If prev valid and idx==prev, idx = (idx+1) mod NUM_HOLES.
  - Latch prev=idx; round+1.
  - Load timer=cur_up; mole=onehot(idx) from next cycle; go to UP.
- UP:
  - Any cycle with hit[idx]=1: score+1 (saturate at 255), hit_pulse=1, mole=0, timer=GAP_TICKS, go to GAP.
  - Else on tick: if timer==1, misses+1, miss_pulse=1, mole=0, timer=GAP_TICKS, go to GAP; otherwise timer-1. The mole is therefore up for exactly cur_up ticks.
  - Hits on other bits are ignored.
  - hit[idx] and the final tick in the same cycle: the hit wins, and no miss is counted.
- GAP:
  - mole=0; hits ignored.
  - On tick: if timer==1, evaluate end; otherwise timer-1.
  - End: go to OVER if round==ROUNDS or misses>=MAX_MISSES; otherwise go to SPAWN.
- OVER: game_over=1; score, misses and round hold until the next start.
- Reset mid-game returns to IDLE immediately, with mole=0 in the same cycle (async).
- tick while in SPAWN has no effect.

Optional Feature:
Macro MOLE_SCHEDULER_SPEEDUP_EN.
- Defined: every 4th scored hit (score[1:0] becomes 00 after the increment) sets cur_up = max(cur_up-2, MIN_UP_TICKS). The new value takes effect at the next SPAWN and resets to UP_TICKS on start.
- Undefined: cur_up is constant UP_TICKS; MIN_UP_TICKS is unused.

Test Plan:
- Reset then start, rand=10, NUM_HOLES=9 -> after SPAWN mole=9'b000000001, round=1, score=0.
- Mole at hole 0, no hit, 20 ticks -> miss_pulse on the 20th tick, misses=1. After 5 further ticks, SPAWN with rand=19 -> idx 0 repeats -> mole=9'b000000010.
- Mole at hole 3, hit=bit 5 then bit 3 -> first hit ignored; second gives score=1, hit_pulse=1 cycle, mole=0.
- hit[idx] in the same cycle as the 20th tick -> score=1, misses=0.
- Never hit, MAX_MISSES=5 -> game_over=1 after the 5th gap, round=5. A start pulse then clears score, misses and round to 0.
- SPEEDUP_EN, 8 consecutive hits -> up time 20, then 18 from mole 5, then 16 from mole 9. A start pulse restores 20.

Source files
------------

// File: rtl/mole_scheduler_if.sv
// Whack-a-mole scheduler bus: random source, game tick, start, buttons in; mole/score status out.
// The random input is named rand_val because rand is a reserved word in SystemVerilog.
interface mole_scheduler_if #(
   parameter int NUM_HOLES = 9
);
   logic [4:0]           rand_val;
   logic                 tick;
   logic                 start;
   logic [NUM_HOLES-1:0] hit;
   logic [NUM_HOLES-1:0] mole;
   logic [7:0]           score;
   logic [7:0]           misses;
   logic [7:0]           round;
   logic                 hit_pulse;
   logic                 miss_pulse;
   logic                 game_over;

   modport master (
      output rand_val, tick, start, hit,
      input  mole, score, misses, round, hit_pulse, miss_pulse, game_over
   );

   modport slave (
      input  rand_val, tick, start, hit,
      output mole, score, misses, round, hit_pulse, miss_pulse, game_over
   );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks holes, times up/gap windows, judges hits and keeps score.
// Optional macro MOLE_SCHEDULER_SPEEDUP_EN shortens the up time by 2 ticks every 4th scored hit.
module mole_scheduler #(
   parameter int NUM_HOLES    = 9,
   parameter int UP_TICKS     = 20,
   parameter int GAP_TICKS    = 5,
   parameter int ROUNDS       = 30,
   parameter int MAX_MISSES   = 5,
   parameter int MIN_UP_TICKS = 6
) (
   input  logic              clk,
   input  logic              rst,
   mole_scheduler_if.slave   sif
);

   localparam int IW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
   // Up time never starts below the speedup floor, even if misconfigured.
   localparam logic [7:0] UP_INIT = 8'((UP_TICKS < MIN_UP_TICKS) ? MIN_UP_TICKS : UP_TICKS);

   typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

   state_t               state;
   logic [IW-1:0]        prev;
   logic                 prev_vld;
   logic [7:0]           timer;
   logic [7:0]           cur_up;
   logic [7:0]           score_r;
   logic [7:0]           misses_r;
   logic [7:0]           round_r;
   logic [NUM_HOLES-1:0] mole_r;
   logic                 hit_pulse_r;
   logic                 miss_pulse_r;
   logic                 game_over_r;

   logic [4:0]           rnd_m1;
   logic [IW-1:0]        base;
   logic [IW-1:0]        pick;
   logic [7:0]           score_inc;
   logic                 start_ok;
   logic                 hit_ok;

   // rand=0 is folded onto hole 0; a repeat of the last hole steps to the next one.
   always_comb begin
      rnd_m1 = 5'd0;
      if (sif.rand_val != 5'd0) rnd_m1 = sif.rand_val - 5'd1;
      base = IW'(rnd_m1 % 5'(NUM_HOLES));
      pick = base;
      if (prev_vld && (base == prev))
         pick = (base == IW'(NUM_HOLES - 1)) ? '0 : base + 1'b1;
   end

   assign score_inc = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
   assign start_ok  = ((state == IDLE) || (state == OVER)) && sif.start;
   assign hit_ok    = (state == UP) && sif.hit[prev];

`ifdef MOLE_SCHEDULER_SPEEDUP_EN
   localparam logic [8:0] FLOOR = 9'(MIN_UP_TICKS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cur_up <= UP_INIT;
      else if (start_ok)
         cur_up <= UP_INIT;
      else if (hit_ok && (score_inc[1:0] == 2'b00))
         cur_up <= ({1'b0, cur_up} >= (FLOOR + 9'd2)) ? cur_up - 8'd2 : FLOOR[7:0];
   end
`else
   assign cur_up = UP_INIT;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         prev         <= '0;
         prev_vld     <= 1'b0;
         timer        <= 8'd0;
         score_r      <= 8'd0;
         misses_r     <= 8'd0;
         round_r      <= 8'd0;
         mole_r       <= '0;
         hit_pulse_r  <= 1'b0;
         miss_pulse_r <= 1'b0;
         game_over_r  <= 1'b0;
      end else begin
         hit_pulse_r  <= 1'b0;
         miss_pulse_r <= 1'b0;
         case (state)
            IDLE, OVER: begin
               if (sif.start) begin
                  score_r     <= 8'd0;
                  misses_r    <= 8'd0;
                  round_r     <= 8'd0;
                  prev_vld    <= 1'b0;
                  game_over_r <= 1'b0;
                  state       <= SPAWN;
               end
            end
            SPAWN: begin
               prev     <= pick;
               prev_vld <= 1'b1;
               round_r  <= round_r + 8'd1;
               timer    <= cur_up;
               mole_r   <= NUM_HOLES'(1) << pick;
               state    <= UP;
            end
            UP: begin
               // A hit on the active hole beats a simultaneous final tick.
               if (sif.hit[prev]) begin
                  score_r     <= score_inc;
                  hit_pulse_r <= 1'b1;
                  mole_r      <= '0;
                  timer       <= 8'(GAP_TICKS);
                  state       <= GAP;
               end else if (sif.tick) begin
                  if (timer == 8'd1) begin
                     misses_r     <= misses_r + 8'd1;
                     miss_pulse_r <= 1'b1;
                     mole_r       <= '0;
                     timer        <= 8'(GAP_TICKS);
                     state        <= GAP;
                  end else begin
                     timer <= timer - 8'd1;
                  end
               end
            end
            GAP: begin
               mole_r <= '0;
               if (sif.tick) begin
                  if (timer == 8'd1) begin
                     if ((round_r == 8'(ROUNDS)) || (misses_r >= 8'(MAX_MISSES))) begin
                        game_over_r <= 1'b1;
                        state       <= OVER;
                     end else begin
                        state <= SPAWN;
                     end
                  end else begin
                     timer <= timer - 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sif.mole       = mole_r;
   assign sif.score      = score_r;
   assign sif.misses     = misses_r;
   assign sif.round      = round_r;
   assign sif.hit_pulse  = hit_pulse_r;
   assign sif.miss_pulse = miss_pulse_r;
   assign sif.game_over  = game_over_r;

endmodule
